// File: rtl/rv_ctrl_pkg.sv
// Shared control definitions for the RV32I decode stage: opcodes, branch types,
// ALU operation classes and the packed control bundle carried into EX.
package rv_ctrl_pkg;

  localparam logic [6:0] OP_R      = 7'b0110011;
  localparam logic [6:0] OP_I      = 7'b0010011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;

  typedef enum logic [2:0] {
    BR_NONE = 3'd0,
    BR_BEQ  = 3'd1,
    BR_BNE  = 3'd2,
    BR_BLT  = 3'd3,
    BR_BGE  = 3'd4,
    BR_BLTU = 3'd5,
    BR_BGEU = 3'd6
  } br_type_e;

  localparam logic [1:0] ALU_ADD   = 2'b00;
  localparam logic [1:0] ALU_CMP   = 2'b01;
  localparam logic [1:0] ALU_FUNCT = 2'b10;

  typedef struct packed {
    br_type_e   br_type;
    logic       mem_read;
    logic       mem_write;
    logic       memtoreg;
    logic       alu_src;
    logic       reg_write;
    logic       jal;
    logic       jalr;
    logic       auipc;
    logic       lui;
    logic [1:0] alu_op;
    logic       illegal;
  } ctrl_t;

  localparam ctrl_t CTRL_NOP = '0;

endpackage

// File: rtl/rv_ctrl_decode.sv
// Combinational main control decoder: opcode/funct3 to control bundle plus
// source-register use flags for hazard detection.
module rv_ctrl_decode
  import rv_ctrl_pkg::*;
#(
  parameter bit UBR_EN = 1'b1
) (
  input  logic [6:0] opcode,
  input  logic [2:0] funct3,
  output ctrl_t      ctrl,
  output logic       rs1_use,
  output logic       rs2_use
);

  logic bad;

  always_comb begin
    ctrl    = CTRL_NOP;
    rs1_use = 1'b0;
    rs2_use = 1'b0;
    bad     = 1'b0;
    case (opcode)
      OP_R: begin
        ctrl.reg_write = 1'b1;
        ctrl.alu_op    = ALU_FUNCT;
        rs1_use        = 1'b1;
        rs2_use        = 1'b1;
      end
      OP_I: begin
        ctrl.reg_write = 1'b1;
        ctrl.alu_src   = 1'b1;
        ctrl.alu_op    = ALU_FUNCT;
        rs1_use        = 1'b1;
      end
      OP_LOAD: begin
        ctrl.mem_read  = 1'b1;
        ctrl.memtoreg  = 1'b1;
        ctrl.alu_src   = 1'b1;
        ctrl.reg_write = 1'b1;
        ctrl.alu_op    = ALU_ADD;
        rs1_use        = 1'b1;
      end
      OP_STORE: begin
        ctrl.mem_write = 1'b1;
        ctrl.alu_src   = 1'b1;
        ctrl.alu_op    = ALU_ADD;
        rs1_use        = 1'b1;
        rs2_use        = 1'b1;
      end
      OP_BRANCH: begin
        ctrl.alu_op = ALU_CMP;
        rs1_use     = 1'b1;
        rs2_use     = 1'b1;
        case (funct3)
          3'b000:  ctrl.br_type = BR_BEQ;
          3'b001:  ctrl.br_type = BR_BNE;
          3'b100:  ctrl.br_type = BR_BLT;
          3'b101:  ctrl.br_type = BR_BGE;
          3'b110:  if (UBR_EN) ctrl.br_type = BR_BLTU; else bad = 1'b1;
          3'b111:  if (UBR_EN) ctrl.br_type = BR_BGEU; else bad = 1'b1;
          default: bad = 1'b1;
        endcase
      end
      OP_JAL: begin
        ctrl.jal       = 1'b1;
        ctrl.reg_write = 1'b1;
      end
      OP_JALR: begin
        ctrl.jalr      = 1'b1;
        ctrl.reg_write = 1'b1;
        ctrl.alu_src   = 1'b1;
        ctrl.alu_op    = ALU_ADD;
        rs1_use        = 1'b1;
      end
      OP_LUI: begin
        ctrl.lui       = 1'b1;
        ctrl.reg_write = 1'b1;
        ctrl.alu_src   = 1'b1;
      end
      OP_AUIPC: begin
        ctrl.auipc     = 1'b1;
        ctrl.reg_write = 1'b1;
        ctrl.alu_src   = 1'b1;
      end
      default: bad = 1'b1;
    endcase
    // An illegal word must never write back or touch memory, nor stall the front end.
    if (bad) begin
      ctrl         = CTRL_NOP;
      ctrl.illegal = 1'b1;
      rs1_use      = 1'b0;
      rs2_use      = 1'b0;
    end
  end

endmodule

// File: rtl/rv_decode_stage.sv
// Registered RV32I decode stage: control decode, load-use hazard detection,
// flush/hold priority into the ID/EX control register, illegal-instruction counter.
module rv_decode_stage
  import rv_ctrl_pkg::*;
#(
  parameter int REG_AW    = 5,
  parameter bit UBR_EN    = 1'b1,
  parameter bit HAZARD_EN = 1'b1,
  parameter int ILL_CNT_W = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 instr_valid,
  input  logic [31:0]          instr,
  input  logic                 flush,
  input  logic                 hold_in,
  output logic                 stall_if,
  output logic                 ctrl_valid,
  output logic [2:0]           br_type,
  output logic                 mem_read,
  output logic                 mem_write,
  output logic                 memtoreg,
  output logic                 alu_src,
  output logic                 reg_write,
  output logic                 jal,
  output logic                 jalr,
  output logic                 auipc,
  output logic                 lui,
  output logic [1:0]           alu_op,
  output logic [REG_AW-1:0]    rs1,
  output logic [REG_AW-1:0]    rs2,
  output logic [REG_AW-1:0]    rd,
  output logic                 illegal,
  output logic [ILL_CNT_W-1:0] ill_count
);

  function automatic logic [ILL_CNT_W-1:0] sat_inc(input logic [ILL_CNT_W-1:0] v);
    return (&v) ? v : v + 1'b1;
  endfunction

  ctrl_t               ctrl_dec;
  logic                rs1_use, rs2_use;
  logic [REG_AW-1:0]   rs1_dec, rs2_dec, rd_dec;
  logic                hazard;
  logic                unused_instr_bits;

  ctrl_t               ctrl_p1;
  logic                vld_p1;
  logic [REG_AW-1:0]   rs1_p1, rs2_p1, rd_p1;
  logic [ILL_CNT_W-1:0] ill_cnt_p1;

  assign rd_dec  = instr[7 +: REG_AW];
  assign rs1_dec = instr[15 +: REG_AW];
  assign rs2_dec = instr[20 +: REG_AW];
  assign unused_instr_bits = ^instr[31:25];

  rv_ctrl_decode #(.UBR_EN(UBR_EN)) u_dec (
    .opcode  (instr[6:0]),
    .funct3  (instr[14:12]),
    .ctrl    (ctrl_dec),
    .rs1_use (rs1_use),
    .rs2_use (rs2_use)
  );

  // A load in ID/EX whose destination feeds this instruction needs one bubble.
  assign hazard = HAZARD_EN && instr_valid && vld_p1 && ctrl_p1.mem_read &&
                  (rd_p1 != '0) &&
                  ((rs1_use && (rs1_dec == rd_p1)) || (rs2_use && (rs2_dec == rd_p1)));

  assign stall_if = hazard | hold_in;

  // ---- ID/EX boundary ----
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      vld_p1     <= 1'b0;
      ctrl_p1    <= CTRL_NOP;
      rs1_p1     <= '0;
      rs2_p1     <= '0;
      rd_p1      <= '0;
      ill_cnt_p1 <= '0;
    end else if (flush) begin
      vld_p1  <= 1'b0;
      ctrl_p1 <= CTRL_NOP;
    end else if (hold_in) begin
      vld_p1  <= vld_p1;
    end else if (hazard) begin
      vld_p1  <= 1'b0;
      ctrl_p1 <= CTRL_NOP;
    end else begin
      vld_p1  <= instr_valid;
      ctrl_p1 <= instr_valid ? ctrl_dec : CTRL_NOP;
      rs1_p1  <= rs1_dec;
      rs2_p1  <= rs2_dec;
      rd_p1   <= rd_dec;
      if (instr_valid && ctrl_dec.illegal)
        ill_cnt_p1 <= sat_inc(ill_cnt_p1);
    end
  end

  assign ctrl_valid = vld_p1;
  assign br_type    = ctrl_p1.br_type;
  assign mem_read   = ctrl_p1.mem_read;
  assign mem_write  = ctrl_p1.mem_write;
  assign memtoreg   = ctrl_p1.memtoreg;
  assign alu_src    = ctrl_p1.alu_src;
  assign reg_write  = ctrl_p1.reg_write;
  assign jal        = ctrl_p1.jal;
  assign jalr       = ctrl_p1.jalr;
  assign auipc      = ctrl_p1.auipc;
  assign lui        = ctrl_p1.lui;
  assign alu_op     = ctrl_p1.alu_op;
  assign illegal    = ctrl_p1.illegal;
  assign rs1        = rs1_p1;
  assign rs2        = rs2_p1;
  assign rd         = rd_p1;
  assign ill_count  = ill_cnt_p1;

endmodule
